// File: rtl/tx_frame_build.sv
// tx_frame_build
//
// Builds one Ethernet frame per accepted send request as a stream of 16-bit
// words numbered from 1: three destination MAC words, three source MAC words,
// the EtherType, then the payload read from the transmit buffer, then zero
// padding up to MIN_WORDS. After the last word it pulses o_sendDn and holds
// off for IFG_WORDS idle cycles before it accepts another request.
//
// Handshake: this is a push interface with no back-pressure. o_tx_valid is
// high on every cycle of a frame, and the words are contiguous. The buffer
// side is a read strobe: o_pl_rd_en at cycle t means i_pl_data holds the
// next payload word at cycle t+1. i_send_req is a level that is looked at
// only in IDLE.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_local_node_mac      source MAC, latched at acceptance
//   i_send_req            send request level
//   i_dst_mac, i_eth_type destination MAC / EtherType, latched at acceptance
//   i_payload_len         payload bytes, latched at acceptance
//   o_pl_rd_en, i_pl_data transmit buffer read strobe / data (1-cycle latency)
//   o_tx_data, o_tx_valid frame word and its valid
//   o_wordNum             current word number 1..N, 0 when not valid
//   o_tx_sof, o_tx_eof    first / last word markers
//   o_sendDn              one-cycle pulse after the last word
//   o_send_busy           block is not in IDLE
//   o_len_err             one-cycle pulse when a request is rejected
module tx_frame_build #(
  parameter int MIN_WORDS = 30,
  parameter int MAX_LEN   = 1500,
  parameter int IFG_WORDS = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] i_local_node_mac,
  input  logic        i_send_req,
  input  logic [47:0] i_dst_mac,
  input  logic [15:0] i_eth_type,
  input  logic [10:0] i_payload_len,
  output logic        o_pl_rd_en,
  input  logic [15:0] i_pl_data,
  output logic [15:0] o_tx_data,
  output logic        o_tx_valid,
  output logic [9:0]  o_wordNum,
  output logic        o_tx_sof,
  output logic        o_tx_eof,
  output logic        o_sendDn,
  output logic        o_send_busy,
  output logic        o_len_err
);

  localparam int GW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PAD,
    S_DONE,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [9:0]    word_q;      // word currently presented
  logic [9:0]    n_q;         // total words N
  logic [9:0]    last_pl_q;   // 7+P, number of the last payload word
  logic          odd_q;       // payload length is odd
  logic [47:0]   dst_q;
  logic [47:0]   src_q;
  logic [15:0]   type_q;
  logic [15:0]   data_q;      // header / pad word
  logic          valid_q;
  logic          sof_q;
  logic          eof_q;
  logic          dn_q;
  logic          err_q;
  logic          rd_q;
  logic [GW-1:0] gap_q;

  // Request decode, used only in the acceptance cycle.
  logic [9:0] acc_p;
  logic [9:0] acc_last;
  logic [9:0] acc_n;
  logic       len_bad;

  assign acc_p    = {1'b0, i_payload_len[10:1]} + {9'b0, i_payload_len[0]};
  assign acc_last = 10'd7 + acc_p;
  assign acc_n    = (acc_last < 10'(MIN_WORDS)) ? 10'(MIN_WORDS) : acc_last;
  assign len_bad  = (i_payload_len > 11'(MAX_LEN));

  // Next word number and the header word it carries (if any).
  logic [9:0]  nxt;
  logic [15:0] hdr_nxt;

  assign nxt = word_q + 10'd1;

  always_comb begin
    hdr_nxt = 16'h0000;
    case (nxt)
      10'd1:   hdr_nxt = dst_q[47:32];
      10'd2:   hdr_nxt = dst_q[31:16];
      10'd3:   hdr_nxt = dst_q[15:0];
      10'd4:   hdr_nxt = src_q[47:32];
      10'd5:   hdr_nxt = src_q[31:16];
      10'd6:   hdr_nxt = src_q[15:0];
      10'd7:   hdr_nxt = type_q;
      default: hdr_nxt = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      n_q       <= '0;
      last_pl_q <= '0;
      odd_q     <= 1'b0;
      dst_q     <= '0;
      src_q     <= '0;
      type_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      gap_q     <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_send_req) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              dst_q     <= i_dst_mac;
              src_q     <= i_local_node_mac;
              type_q    <= i_eth_type;
              odd_q     <= i_payload_len[0];
              n_q       <= acc_n;
              last_pl_q <= acc_last;
              word_q    <= 10'd1;
              data_q    <= i_dst_mac[47:32];
              valid_q   <= 1'b1;
              sof_q     <= 1'b1;
              eof_q     <= 1'b0;
              rd_q      <= 1'b0;
              state_q   <= S_HDR;
            end
          end
        end

        S_HDR, S_PAYLOAD, S_PAD: begin
          sof_q <= 1'b0;
          if (word_q == n_q) begin
            state_q <= S_DONE;
            word_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            rd_q    <= 1'b0;
            dn_q    <= 1'b1;
          end else begin
            word_q <= nxt;
            eof_q  <= (nxt == n_q);
            // The strobe leads the payload word by one cycle, so it covers
            // words 7..6+P; nothing is fetched when P=0 (last_pl_q = 7).
            rd_q   <= (nxt >= 10'd7) && (nxt < last_pl_q);
            if (nxt <= 10'd7) begin
              state_q <= S_HDR;
              data_q  <= hdr_nxt;
            end else if (nxt <= last_pl_q) begin
              state_q <= S_PAYLOAD;
              data_q  <= '0;
            end else begin
              state_q <= S_PAD;
              data_q  <= '0;
            end
          end
        end

        S_DONE: begin
          dn_q    <= 1'b0;
          gap_q   <= '0;
          state_q <= S_GAP;
        end

        S_GAP: begin
          if (gap_q == GW'(IFG_WORDS - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Payload words pass straight through from the buffer; an odd length
  // leaves the low byte of the final payload word unused, so it is zeroed.
  always_comb begin
    o_tx_data = data_q;
    if (state_q == S_PAYLOAD) begin
      o_tx_data = i_pl_data;
      if (odd_q && (word_q == last_pl_q)) begin
        o_tx_data[7:0] = 8'h00;
      end
    end
  end

  assign o_tx_valid  = valid_q;
  assign o_wordNum   = word_q;
  assign o_tx_sof    = sof_q;
  assign o_tx_eof    = eof_q;
  assign o_sendDn    = dn_q;
  assign o_len_err   = err_q;
  assign o_pl_rd_en  = rd_q;
  assign o_send_busy = (state_q != S_IDLE);

endmodule

// File: doc/tx_frame_build.md
# tx_frame_build

Transmit-side frame builder for the MAC. On a send request it emits one Ethernet frame as consecutive 16-bit words: destination MAC, local source MAC and EtherType, then payload fetched from the transmit buffer, then zero padding up to the minimum frame size. Word numbering is 1-based and matches the receive path, so word 1 carries dst[47:32]. It sits between the transmit buffer and the PHY-side serializer/FCS generator, and enforces an inter-frame gap before the next frame.

## Interface
- MIN_WORDS, 30: minimum frame length in words, excluding FCS (60 bytes).
- MAX_LEN, 1500: maximum payload length in bytes.
- IFG_WORDS, 6: idle cycles after sendDn before the next request is accepted.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_local_node_mac  in  48  source MAC; sampled at acceptance.
- i_send_req  in  1  send request; level, sampled only in IDLE.
- i_dst_mac  in  48  destination MAC; sampled at acceptance.
- i_eth_type  in  16  EtherType; sampled at acceptance.
- i_payload_len  in  11  payload length in bytes; sampled at acceptance.
- o_pl_rd_en  out  1  payload read strobe to the transmit buffer.
- i_pl_data  in  16  payload word; valid the cycle after o_pl_rd_en. The first byte is in [15:8].
- o_tx_data  out  16  frame word.
- o_tx_valid  out  1  o_tx_data is valid; high every cycle of a frame.
- o_wordNum  out  10  current word number, 1..N; 0 when not valid.
- o_tx_sof / o_tx_eof  out  1  high with word 1 / word N respectively.
- o_sendDn  out  1  one-cycle pulse after the last word.
- o_send_busy  out  1  block is not in IDLE.
- o_len_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, HDR, PAYLOAD, PAD, DONE, GAP.
- Acceptance condition: IDLE and i_send_req=1.
  - If i_payload_len > MAX_LEN: pulse o_len_err next cycle, stay in IDLE, emit nothing.
  - Otherwise latch all request inputs, set P = ceil(len/2) and N = max(7+P, MIN_WORDS), then enter HDR.
- HDR emits words 1–7:
  - Words 1–3: dst[47:32], dst[31:16], dst[15:0].
  - Words 4–6: src in the same order.
  - Word 7: EtherType.
- HDR → PAYLOAD if P>0, else PAD.
- PAYLOAD emits words 8..7+P, with o_tx_data = i_pl_data (combinational path).
  - If len is odd, the final payload word has [7:0] forced to 0.
- PAYLOAD → PAD if 7+P < N, else DONE. PAD emits 16'h0000 until word N, then → DONE.
- o_pl_rd_en is high during the cycles presenting words 7..6+P, exactly P strobes per frame. It is never asserted when P=0.
- DONE lasts one cycle with o_sendDn=1. GAP lasts IFG_WORDS cycles, then → IDLE.
- i_send_req outside IDLE is ignored; there is no queueing. Held latched fields are unaffected by input changes mid-frame.
- Reset value of all outputs is 0, and state is IDLE. Reset mid-frame truncates the frame immediately: no eof, no sendDn. The next accepted request starts at word 1.

## Timing
- Request accepted at cycle T: word 1 with sof is presented at T+1. Words are contiguous with no bubbles, so word k is at T+k.
- Last word N is at E=T+N with eof. o_sendDn is at E+1. GAP spans E+2..E+1+IFG_WORDS, and IDLE is reached at E+2+IFG_WORDS.
- With the request held high, the next frame's word 1 is at E+3+IFG_WORDS, which is E+9 for the default.
- o_send_busy is 1 from T+1 through E+1+IFG_WORDS. It is 0 during the acceptance cycle.
- o_len_err asserts at T+1 on rejection; o_send_busy stays 0.
- Payload read latency is exactly 1 cycle: strobe at cycle t, data consumed at t+1.
- o_wordNum is 10 bits. The maximum is 757 (len=1500).

## Test plan
- len=46, dst=01005e000181, src=001122334455, type=88b8 → words 1–7 = 0100,5e00,0181,0011,2233,4455,88b8. Then 23 payload words with 23 rd_en strobes, N=30, no pad. eof at word 30, sendDn at T+31, busy low at T+38.
- len=0 → 7 header words, then 23 words of 0000. N=30, zero rd_en strobes.
- len=61, last buffer word ABCD → P=31, N=38. Word 38 = AB00; no pad.
- len=1500 → N=757, 750 strobes, wordNum reaches 757. len=1501 → o_len_err pulse at T+1, no o_tx_valid, busy stays 0.
- Request held high continuously → second frame sof exactly 9 cycles after the first eof. A request pulse during busy produces no frame.
- Assert i_rst_n low at word 12 → all outputs 0 in the same cycle, no sendDn. The next request restarts at word 1 with the correct header.
